// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/negate_32.sv
// Two's-complement negation (invert plus one), purely combinational.
module negate_32
    import multdiv_pkg::*;
(
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = ~din + WIDTH'(1);

endmodule

// File: rtl/multdiv_unit.sv
// Radix-2 signed multiply/divide, one iteration per cycle on operand magnitudes.
// Define MULTDIV_DIV_EN to build the divide datapath; otherwise divide reports an exception.
module multdiv_unit #(
    parameter int WIDTH = multdiv_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    import multdiv_pkg::*;

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic [WIDTH-1:0]   a_neg, b_neg, r_neg, a_mag, b_mag;
    logic               start_req;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH-1:0]   mag_hi;
    logic               fits, div_fault;

    negate_32 u_neg_a (.din(data_operandA),  .dout(a_neg));
    negate_32 u_neg_b (.din(data_operandB),  .dout(b_neg));
    negate_32 u_neg_r (.din(acc_q[WIDTH-1:0]), .dout(r_neg));

    assign a_mag     = data_operandA[WIDTH-1] ? a_neg : data_operandA;
    assign b_mag     = data_operandB[WIDTH-1] ? b_neg : data_operandB;
    assign start_req = ((state_q == IDLE) || (state_q == DONE)) && (ctrl_MULT || ctrl_DIV);

    // Shift-add: the multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

`ifdef MULTDIV_DIV_EN
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_step;

    // Restoring divide: remainder in the high half, quotient bits shift into the low half.
    assign div_diff = {1'b0, acc_q[2*WIDTH-2:WIDTH-1]} - {1'b0, opnd_q};
    assign div_step = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

    // A negative result may reach -2^(W-1); a positive one must stay below 2^(W-1).
    assign mag_hi    = is_div_q ? '0 : acc_q[2*WIDTH-1:WIDTH];
    assign fits      = (mag_hi == '0) &&
                       (!acc_q[WIDTH-1] || (sign_q && (acc_q[WIDTH-2:0] == '0)));
    assign div_fault = is_div_q && (!DIV_EN || (opnd_q == '0));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_req) state_d = (ctrl_MULT || DIV_EN) ? BUSY : FIX;
            BUSY:       if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
            FIX:        state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output defaults to hold first, so no path can infer a latch.
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_req) begin
                    cnt_d    = '0;
                    is_div_d = !ctrl_MULT;
                    sign_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    opnd_d   = ctrl_MULT ? a_mag : b_mag;
                    acc_d    = {{WIDTH{1'b0}}, (ctrl_MULT ? b_mag : a_mag)};
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef MULTDIV_DIV_EN
                acc_d = is_div_q ? div_step : mul_step;
`else
                acc_d = mul_step;
`endif
            end
            FIX: begin
                result_d = div_fault ? '0 : (sign_q ? r_neg : acc_q[WIDTH-1:0]);
                exc_d    = div_fault || !fits;
                rdy_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed vectors queue expectations, a monitor
// checks each resultRDY pulse. Expected divide results follow MULTDIV_DIV_EN.
module tb_multdiv_unit;

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int LAT_FULL = 34;
    localparam int LAT_NODIV = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: every resultRDY pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rdy: pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_res"}, data_result, e.res);
                check({e.name, "_exc"}, {31'b0, data_exception}, {31'b0, e.exc});
                check({e.name, "_cyc"}, cyc, e.cyc);
            end
        end
    end

    // The registered pulse is visible between edges s+lat-1 and s+lat.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res,
                            input logic exc, input int lat, input string name);
        exp_t e;
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        e.name = name;
        e.res = res;
        e.exc = exc;
        e.cyc = cyc + lat - 1;
        sb.push_back(e);
    endtask

    task automatic mul_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc, input string name);
        start_op(1'b1, 1'b0, a, b, res, exc, LAT_FULL, name);
    endtask

    task automatic div_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc, input string name);
        if (DIV_EN) start_op(1'b0, 1'b1, a, b, res, exc, LAT_FULL, name);
        else        start_op(1'b0, 1'b1, a, b, 32'h0, 1'b1, LAT_NODIV, name);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clock);
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("reset_res", data_result, 32'h0);
        check("reset_exc", {31'b0, data_exception}, 32'h0);
        check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        mul_op(32'd7,        32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, "mul_7x-6");     wait_done("mul_7x-6");
        mul_op(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf32");   wait_done("mul_ovf32");
        mul_op(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1, "mul_ffff2");   wait_done("mul_ffff2");
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_m1xm1");   wait_done("mul_m1xm1");
        mul_op(32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, "mul_minx1");   wait_done("mul_minx1");
        mul_op(32'h4000_0000, 32'h0000_0002, 32'h8000_0000, 1'b1, "mul_pos_edge"); wait_done("mul_pos_edge");
        mul_op(32'hC000_0000, 32'h0000_0002, 32'h8000_0000, 1'b0, "mul_neg_edge"); wait_done("mul_neg_edge");
        mul_op(32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, "mul_0x-5");    wait_done("mul_0x-5");

        div_op(32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_-7/2");    wait_done("div_-7/2");
        div_op(32'd5,         32'd0,         32'h0000_0000, 1'b1, "div_5/0");     wait_done("div_5/0");
        div_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_min/-1");  wait_done("div_min/-1");
        div_op(32'd100,       32'd7,         32'd14,        1'b0, "div_100/7");   wait_done("div_100/7");
        div_op(32'd7,         32'hFFFF_FF9C, 32'h0000_0000, 1'b0, "div_7/-100");  wait_done("div_7/-100");
        div_op(32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0, "div_min/2");   wait_done("div_min/2");

        // Both controls high: multiply wins.
        start_op(1'b1, 1'b1, 32'd5, 32'd3, 32'd15, 1'b0, LAT_FULL, "prio_mul");
        wait_done("prio_mul");

        // A second start mid-operation is ignored; the previous result holds during BUSY.
        mul_op(32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, "ignore_start");
        repeat (8) @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd100;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        check("busy_hold_res", data_result, 32'd15);
        wait_done("ignore_start");
        repeat (40) @(posedge clock);

        // Reset mid-operation aborts without a pulse.
        mul_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "pre_reset");
        wait_done("pre_reset");
        mul_op(32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, "aborted");
        repeat (14) @(posedge clock);
        #1 reset_n = 1'b0;
        sb.delete();
        #1;
        check("abort_res", data_result, 32'h0);
        check("abort_exc", {31'b0, data_exception}, 32'h0);
        check("abort_rdy", {31'b0, data_resultRDY}, 32'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(posedge clock);
        mul_op(32'd3, 32'd3, 32'd9, 1'b0, "post_reset");
        wait_done("post_reset");

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ctrl_MULT  in  1  start signed multiply, sampled each edge.
REQ-005 SHALL have port ctrl_DIV  in  1  start signed divide, sampled each edge.
REQ-006 SHALL have port data_operandA  in  32  multiplicand / dividend, two's complement.
REQ-007 SHALL have port data_operandB  in  32  multiplier / divisor, two's complement.
REQ-008 SHALL have port data_result  out  32  product low word or quotient.
REQ-009 SHALL have port data_exception  out  1  overflow / divide-by-zero flag, valid with data_result.
REQ-010 SHALL have port data_resultRDY  out  1  one-cycle pulse marking completion.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, FIX, DONE.
REQ-012 SHALL, in IDLE or DONE, on an edge with ctrl_MULT or ctrl_DIV high, latch both operands and the op, clear the 5-bit iteration counter and enter BUSY.
REQ-013 SHALL give ctrl_MULT priority when both controls are high on the same edge.
REQ-014 SHALL ignore ctrl_MULT and ctrl_DIV while in BUSY or FIX, leaving latched operands unchanged.
REQ-015 SHALL store operand magnitudes (negated via bitwise invert plus one when negative) and record the result sign as the XOR of the operand signs.
REQ-016 SHALL perform one radix-2 iteration per cycle in BUSY: shift-add for multiply, restoring shift-subtract for divide, 64-bit internal accumulator.
REQ-017 SHALL leave BUSY for FIX after exactly 32 iterations; counter wraps 31->0 on that transition.
REQ-018 SHALL, in FIX, negate the result magnitude when the recorded sign is 1, update data_result/data_exception, pulse data_resultRDY for the next cycle, and enter DONE.
REQ-019 SHALL make data_resultRDY high for exactly one cycle, 34 cycles after the start edge.
REQ-020 SHALL hold data_result and data_exception stable in DONE until the next start edge, then keep them stable through BUSY.
REQ-021 SHALL, for multiply, output the low 32 bits of the signed 64-bit product, with data_exception=1 iff the product does not fit in 32 signed bits.
REQ-022 SHALL, for divide, truncate the quotient toward zero and discard the remainder.
REQ-023 SHALL, for divisor 0, output data_result=0 and data_exception=1 with normal latency.
REQ-024 SHALL, for 0x80000000 / 0xFFFFFFFF, output 0x80000000 and data_exception=1.

Reset
REQ-025 SHALL, while reset_n=0, force state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, regardless of clock.
REQ-026 SHALL abort any in-progress operation on reset assertion with no resultRDY pulse; first start edge after reset_n rises is accepted.

Configuration
REQ-027 SHALL, with macro MULTDIV_DIV_EN defined, implement division per REQ-016 to REQ-024.
REQ-028 SHALL, without MULTDIV_DIV_EN, omit divide datapath; ctrl_DIV (when ctrl_MULT low) goes directly to FIX, yields data_result=0, data_exception=1, with data_resultRDY pulsed 2 cycles after the start edge.

Structure
REQ-029 SHALL take FSM state encoding, WIDTH, and iteration count 32 from shared package multdiv_pkg.
REQ-030 SHALL instantiate sub-module negate_32 (bitwise invert plus one, combinational) for operand magnitude and result sign fix.

Verification
REQ-031 SHALL cover: MULT 7 x -6 -> result 0xFFFFFFD6, exception 0, resultRDY pulse at cycle 34.
REQ-032 SHALL cover: MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
REQ-033 SHALL cover: DIV -7 / 2 -> result 0xFFFFFFFD, exception 0; DIV 5 / 0 -> result 0, exception 1.
REQ-034 SHALL cover: DIV 0x80000000 / -1 -> result 0x80000000, exception 1.
REQ-035 SHALL cover: start, then ctrl_MULT pulse at cycle 10 with new operands -> ignored, first result unchanged, single resultRDY pulse.
REQ-036 SHALL cover: reset_n low at cycle 15 of an operation -> all outputs 0 immediately, no resultRDY, next MULT 3 x 3 -> 9.
